// File: rtl/axi_st_pkt_checker.sv
// AXI-Stream sink that checks incrementing-byte test packets against a length/seed carried in tuser,
// counting good packets, errored packets and accepted bytes, with optional LFSR backpressure.
//
// state  | meaning
// IDLE   | waiting for the first beat of a packet
// IN_PKT | mid-packet, no error seen yet
// DROP   | error seen, discarding beats until tlast
module axi_st_pkt_checker #(
  parameter int DATA_WIDTH   = 64,
  parameter int BYTEEN_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_tvalid,
  input  logic [DATA_WIDTH-1:0]   i_tdata,
  input  logic [BYTEEN_WIDTH-1:0] i_tkeep,
  input  logic                    i_tlast,
  input  logic [USER_WIDTH-1:0]   i_tuser,
  output logic                    o_tready,
  input  logic                    i_bp_en,
  input  logic                    i_clr,
  output logic [31:0]             o_pkt_cnt,
  output logic [31:0]             o_byte_cnt,
  output logic [15:0]             o_err_cnt,
  output logic                    o_err_sticky,
  output logic                    o_err_pulse
);

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  localparam logic [7:0] BEAT_BYTES = 8'(BYTEEN_WIDTH);

  state_t                  state_q;
  logic [15:0]             lfsr_q;
  logic                    run_q;
  logic [7:0]              base_q;
  logic [8:0]              beat_q;
  logic [8:0]              len_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic [31:0]             pkt_cnt_q;
  logic [31:0]             byte_cnt_q;
  logic [15:0]             err_cnt_q;
  logic                    sticky_q;
  logic                    pulse_q;

  logic                    acc;
  logic                    in_idle;
  logic [7:0]              cur_base;
  logic [8:0]              cur_beat;
  logic [8:0]              cur_len;
  logic                    data_err;
  logic                    keep_err;
  logic                    user_err;
  logic                    len_err;
  logic                    beat_err;
  logic                    new_err;
  logic                    good_last;
  logic [BYTEEN_WIDTH-1:0] keep_inc;
  logic [31:0]             keep_pop;

  // run_q keeps tready low until the first edge after reset release
  assign o_tready = run_q & (~i_bp_en | lfsr_q[0]);
  assign acc      = i_tvalid & o_tready;

  always_comb begin
    in_idle  = (state_q == IDLE);
    cur_base = in_idle ? i_tuser[7:0] : base_q;
    cur_beat = in_idle ? 9'd0 : beat_q;
    cur_len  = len_q;
    if (in_idle) cur_len = (i_tuser[15:8] == 8'd0) ? 9'd256 : {1'b0, i_tuser[15:8]};
    data_err = 1'b0;
    keep_pop = 32'd0;
    for (int k = 0; k < BYTEEN_WIDTH; k++) begin
      if (i_tkeep[k] && (i_tdata[8*k +: 8] != (cur_base + 8'(k)))) data_err = 1'b1;
      keep_pop = keep_pop + 32'(i_tkeep[k]);
    end
    // a contiguous-from-bit-0 mask plus one has no bits in common with the mask
    keep_inc = i_tkeep + {{(BYTEEN_WIDTH-1){1'b0}}, 1'b1};
    if (i_tlast) keep_err = (i_tkeep == '0) || ((i_tkeep & keep_inc) != '0);
    else         keep_err = (i_tkeep != '1);
    user_err  = !in_idle && (i_tuser != user_q);
    len_err   = i_tlast != (cur_beat == (cur_len - 9'd1));
    beat_err  = data_err | keep_err | user_err | len_err;
    new_err   = acc && (state_q != DROP) && beat_err;
    good_last = acc && (state_q != DROP) && i_tlast && !beat_err;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= 16'hACE1;
      run_q   <= 1'b0;
      base_q  <= 8'd0;
      beat_q  <= 9'd0;
      len_q   <= 9'd0;
      user_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      pulse_q <= new_err;
      if (acc) begin
        case (state_q)
          IDLE, IN_PKT: begin
            if (in_idle) begin
              user_q <= i_tuser;
              len_q  <= cur_len;
            end
            base_q <= cur_base + BEAT_BYTES;
            beat_q <= cur_beat + 9'd1;
            if (i_tlast)       state_q <= IDLE;
            else if (beat_err) state_q <= DROP;
            else               state_q <= IN_PKT;
          end
          DROP:    if (i_tlast) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q  <= 32'd0;
      byte_cnt_q <= 32'd0;
      err_cnt_q  <= 16'd0;
      sticky_q   <= 1'b0;
    end else if (i_clr) begin
      pkt_cnt_q  <= 32'd0;
      byte_cnt_q <= 32'd0;
      err_cnt_q  <= 16'd0;
      sticky_q   <= 1'b0;
    end else begin
      if (acc)       byte_cnt_q <= byte_cnt_q + keep_pop;
      if (good_last) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (new_err) begin
        sticky_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_byte_cnt   = byte_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_err_sticky = sticky_q;
  assign o_err_pulse  = pulse_q;

endmodule

// File: doc/axi_st_pkt_checker.md
AXI_ST_PKT_CHECKER -- requirements
Module: axi_st_pkt_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the tdata width in bits (multiple of 8, 8..1024).
REQ-002 SHALL have parameter BYTEEN_WIDTH, default DATA_WIDTH/8, meaning the tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 16, meaning the tuser width (minimum 16).
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports i_tvalid/i_tdata/i_tkeep/i_tlast/i_tuser  input  1/DATA_WIDTH/BYTEEN_WIDTH/1/USER_WIDTH  AXI-Stream sink-side signals.
REQ-007 SHALL have port o_tready  output  1  AXI-Stream sink ready.
REQ-008 SHALL have port i_bp_en  input  1  enables pseudo-random backpressure.
REQ-009 SHALL have port i_clr  input  1  synchronous clear of counters and the sticky error flag.
REQ-010 SHALL have ports o_pkt_cnt / o_byte_cnt  output  32 / 32  good-packet count and accepted-byte count.
REQ-011 SHALL have ports o_err_cnt / o_err_sticky / o_err_pulse  output  16 / 1 / 1  errored-packet count, sticky flag, and one-cycle error strobe.

Function
REQ-012 SHALL define a beat as accepted only in a cycle where i_tvalid=1 and o_tready=1.
REQ-013 SHALL drive o_tready=1 constantly when i_bp_en=0; when i_bp_en=1, SHALL drive o_tready = bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that advances every cycle.
REQ-014 SHALL implement FSM states IDLE (awaiting first beat), IN_PKT (mid-packet, no error), DROP (error seen, discarding until tlast).
REQ-015 SHALL, in IDLE, latch seed = i_tuser[7:0] and expected length L = i_tuser[15:8] (beats, 0 means 256) on the first accepted beat.
REQ-016 SHALL require byte lane k of beat b (b from 0) to equal (seed + b*BYTEEN_WIDTH + k) mod 256 for every lane with tkeep[k]=1.
REQ-017 SHALL flag an error when any of the following occurs: data mismatch; tkeep not all-ones on a non-last beat; last-beat tkeep not contiguous from bit 0 or all-zero; tuser differs from the first beat; tlast on beat b != L-1; beat count reaches L without tlast.
REQ-018 SHALL, on an error in a beat without tlast, transition to DROP; on a beat with tlast (error or not), transition to IDLE.
REQ-019 SHALL, in DROP, keep accepting beats, ignore their content, and return to IDLE on the accepted tlast beat.
REQ-020 SHALL treat a one-beat packet (tlast on the first beat) as complete in IDLE and remain in IDLE.
REQ-021 SHALL assert o_err_pulse for exactly one cycle, one cycle after the accepted beat in which a packet's first error is detected; errors in the same packet are counted once.
REQ-022 SHALL increment o_pkt_cnt by 1, one cycle after an error-free tlast beat, and o_err_cnt by 1, one cycle after a packet's first error.
REQ-023 SHALL add popcount(i_tkeep) to o_byte_cnt one cycle after every accepted beat, including beats in DROP.
REQ-024 SHALL wrap o_pkt_cnt and o_byte_cnt modulo 2^32 and saturate o_err_cnt at 16'hFFFF.
REQ-025 SHALL set o_err_sticky alongside o_err_pulse and hold it until i_clr or reset.
REQ-026 SHALL, when i_clr coincides with an update, give i_clr priority (counters and sticky become 0); FSM state and the LFSR are unaffected by i_clr.

Reset
REQ-027 SHALL, while i_rst_n=0, force FSM=IDLE, LFSR=16'hACE1, all counters=0, o_err_sticky=0, o_err_pulse=0, and o_tready=0.
REQ-028 SHALL resume o_tready behaviour on the first rising edge after i_rst_n deasserts; a packet interrupted by reset is abandoned and not counted.

Verification
REQ-029 Packet of 4 beats, tuser=16'h0410, DATA_WIDTH=64, last tkeep=8'h0F, correct data -> o_pkt_cnt=1, o_byte_cnt=28, o_err_cnt=0.
REQ-030 Same packet with byte 3 of beat 1 corrupted -> o_err_pulse is high for one cycle after beat 1, FSM enters DROP, o_err_cnt=1, o_pkt_cnt=0, o_byte_cnt=28.
REQ-031 tuser=16'h0300 with tlast on beat 1 -> length error, o_err_cnt=1; the next correct packet is counted, giving o_pkt_cnt=1.
REQ-032 i_bp_en=1 with 100 back-to-back 2-beat packets -> o_tready follows the LFSR sequence from 16'hACE1, o_pkt_cnt=100, and no beat is counted unless valid&&ready.
REQ-033 i_rst_n pulsed low mid-packet -> all outputs are 0 immediately (async); the following correct packet gives o_pkt_cnt=1.
REQ-034 o_err_cnt preloaded at 16'hFFFF via 65535 bad packets, plus 1 more -> o_err_cnt stays 16'hFFFF; then i_clr -> all counters=0 and o_err_sticky=0.
